mem_burst_splitter: RTL and testbench
=====================================

# mem_burst_splitter

Parametrised request splitter for the memory interface path. Each accepted request is cut into a sequence of sub-requests. No sub-request crosses a 2^BOUNDARY_LOG2-byte address boundary or exceeds 2^MAX_BURST_LOG2 bytes. Sits between the store/load request generators and the AXI address channel, and supersedes the fixed 4 KB two-way split. It supports any number of chunks, a burst-length cap, request tags, a bypass mode and full valid/ready flow control on both sides.

## Interface
Parameters:
- ADDR_WIDTH, 64, address width in bits
- REQ_SIZE_WIDTH, 16, request size width in bytes
- BOUNDARY_LOG2, 12, log2 of the no-cross boundary in bytes (4 KB default)
- MAX_BURST_LOG2, 8, log2 of the max sub-request size in bytes; must be ≤ BOUNDARY_LOG2 and < REQ_SIZE_WIDTH
- ID_WIDTH, 4, request tag width

Ports:
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  asynchronous, active-low reset
- split_en  in  1  1 = split; 0 = bypass, forward each request unmodified as a single chunk; sampled at input accept
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_addr  in  ADDR_WIDTH  start byte address
- in_size  in  REQ_SIZE_WIDTH  request size in bytes
- in_id  in  ID_WIDTH  request tag
- out_valid  out  1  sub-request valid
- out_ready  in  1  sub-request consumed when out_valid & out_ready
- out_addr  out  ADDR_WIDTH  sub-request address
- out_size  out  REQ_SIZE_WIDTH  sub-request size in bytes, never 0
- out_id  out  ID_WIDTH  tag copied from the parent request
- out_first  out  1  first chunk of the parent request
- out_last  out  1  last chunk of the parent request
- busy  out  1  a parent request is in progress (state ISSUE)
- req_done  out  1  one-cycle pulse when a parent request completes
- req_done_id  out  ID_WIDTH  tag of the completed request, valid with req_done

## Operation
- States:
  - IDLE: no request held.
  - ISSUE: a request is held in registers. Holds cur_addr, rem_bytes, id, first flag and a bypass flag.
- in_ready = (state==IDLE) | (out_valid & out_ready & out_last). The last term is combinational on out_ready and gives back-to-back acceptance.
- On accept with in_size≠0:
  - Load cur_addr=in_addr, rem_bytes=in_size, first=1, bypass=~split_en.
  - Go to ISSUE.
- On accept with in_size==0:
  - No sub-request is issued.
  - req_done pulses next cycle with req_done_id=in_id.
  - State goes to IDLE, or stays IDLE.
- Chunk size, computed from registers:
  - bnd_rem = 2^BOUNDARY_LOG2 − cur_addr[BOUNDARY_LOG2-1:0], computed in BOUNDARY_LOG2+1 bits.
  - chunk = min(rem_bytes, bnd_rem, 2^MAX_BURST_LOG2).
  - In bypass, chunk = rem_bytes.
- Output fields:
  - out_addr=cur_addr, out_size=chunk, out_id=id, out_first=first.
  - out_last = (chunk==rem_bytes).
  - out_valid = (state==ISSUE).
- On an out handshake that is not last:
  - cur_addr += chunk; the sum wraps modulo 2^ADDR_WIDTH.
  - rem_bytes −= chunk.
  - first=0.
- On the last handshake:
  - req_done pulses the next cycle with the id.
  - If in_valid is also high and in_ready=1, the new request loads in the same cycle and ISSUE is kept. Otherwise go to IDLE.
- While out_valid=1 & out_ready=0, every out_* signal stays stable.
- split_en changes during ISSUE do not affect the request in flight.

## Timing
- Reset (reset=0) forces, asynchronously:
  - state=IDLE, all registers 0.
  - out_valid=0, out_first=0, out_last=0, out_size=0, out_addr=0, out_id=0.
  - busy=0, req_done=0, req_done_id=0.
  - in_ready=1 after release.
- Reset asserted mid-request drops the request: no further chunks and no req_done.
- Latency: a request accepted at edge N presents its first chunk at cycle N+1.
- Each following chunk appears in the cycle after the previous handshake. One chunk per cycle is sustained while out_ready=1.
- A request with k chunks occupies k cycles. With back-to-back overlap, throughput is one single-chunk request per cycle.
- Max chunks per request = ceil(in_size / 2^MAX_BURST_LOG2) + 1.
- req_done asserts the cycle after the last handshake, for exactly one cycle.

## Test plan
- Boundary cross: addr 0x0FF0, size 0x40, split_en=1 → (0x0FF0, 0x10, first) then (0x1000, 0x30, last); req_done 1 cycle after the second handshake.
- Burst cap: addr 0x2000, size 0x300 → (0x2000, 0x100, first), (0x2100, 0x100), (0x2200, 0x100, last); 3 consecutive cycles with out_ready=1.
- Bypass: split_en=0, addr 0x0FF0, size 0x40 → single (0x0FF0, 0x40, first & last).
- Backpressure: drive out_ready=0 for 5 cycles mid-request → outputs bit-stable; chunk sequence unchanged after release. in_valid held high throughout → accepted only at the last handshake, then its first chunk appears the next cycle.
- Zero size and tag: size 0, id 0x5 → no out_valid; req_done with id 0x5 next cycle. Back-to-back single-chunk requests with ids 1, 2, 3 → one out_valid per cycle, in order.
- Reset mid-request: assert reset during chunk 2 of 3 → out_valid=0 immediately; after release in_ready=1, no req_done; a new request works normally.

Source files
------------

// File: rtl/mem_burst_splitter.sv
// Cuts each accepted request into sub-requests that never cross a 2^BOUNDARY_LOG2
// byte boundary nor exceed 2^MAX_BURST_LOG2 bytes; bypass forwards a request whole.
module mem_burst_splitter #(
  parameter int ADDR_WIDTH     = 64,
  parameter int REQ_SIZE_WIDTH = 16,
  parameter int BOUNDARY_LOG2  = 12,
  parameter int MAX_BURST_LOG2 = 8,
  parameter int ID_WIDTH       = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      split_en,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_WIDTH-1:0]     in_addr,
  input  logic [REQ_SIZE_WIDTH-1:0] in_size,
  input  logic [ID_WIDTH-1:0]       in_id,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ADDR_WIDTH-1:0]     out_addr,
  output logic [REQ_SIZE_WIDTH-1:0] out_size,
  output logic [ID_WIDTH-1:0]       out_id,
  output logic                      out_first,
  output logic                      out_last,
  output logic                      busy,
  output logic                      req_done,
  output logic [ID_WIDTH-1:0]       req_done_id
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
  // valid never waits on ready, and an offered sub-request holds every field until taken.

  localparam int CW = (REQ_SIZE_WIDTH > BOUNDARY_LOG2 + 1) ? REQ_SIZE_WIDTH : BOUNDARY_LOG2 + 1;
  localparam logic [BOUNDARY_LOG2:0] BND_BYTES = (BOUNDARY_LOG2 + 1)'(1) << BOUNDARY_LOG2;
  localparam logic [CW-1:0]          MAX_BURST = CW'(1) << MAX_BURST_LOG2;

  // busy mirrors the state register, so the FSM state is visible on the ports.
  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     cur_addr_q, cur_addr_d;
  logic [REQ_SIZE_WIDTH-1:0] rem_q, rem_d;
  logic [ID_WIDTH-1:0]       id_q, id_d;
  logic                      first_q, first_d;
  logic                      bypass_q, bypass_d;
  logic                      done_q, done_d;
  logic [ID_WIDTH-1:0]       done_id_q, done_id_d;

  logic [BOUNDARY_LOG2:0]    bnd_rem;
  logic [CW-1:0]             chunk_w;
  logic [REQ_SIZE_WIDTH-1:0] chunk;
  logic                      in_hs, out_hs;

  assign bnd_rem = BND_BYTES - {1'b0, cur_addr_q[BOUNDARY_LOG2-1:0]};

  always_comb begin
    chunk_w = CW'(rem_q);
    if (!bypass_q) begin
      if (CW'(bnd_rem) < chunk_w) chunk_w = CW'(bnd_rem);
      if (MAX_BURST < chunk_w)    chunk_w = MAX_BURST;
    end
    chunk = REQ_SIZE_WIDTH'(chunk_w);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      rem_q      <= '0;
      id_q       <= '0;
      first_q    <= 1'b0;
      bypass_q   <= 1'b0;
      done_q     <= 1'b0;
      done_id_q  <= '0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      rem_q      <= rem_d;
      id_q       <= id_d;
      first_q    <= first_d;
      bypass_q   <= bypass_d;
      done_q     <= done_d;
      done_id_q  <= done_id_d;
    end
  end

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    rem_d      = rem_q;
    id_d       = id_q;
    first_d    = first_q;
    bypass_d   = bypass_q;
    done_d     = 1'b0;
    done_id_d  = done_id_q;
    if (out_hs) begin
      if (out_last) begin
        done_d    = 1'b1;
        done_id_d = id_q;
        state_d   = IDLE;
      end else begin
        cur_addr_d = cur_addr_q + ADDR_WIDTH'(chunk);
        rem_d      = rem_q - chunk;
        first_d    = 1'b0;
      end
    end
    if (in_hs) begin
      if (in_size != '0) begin
        state_d    = ISSUE;
        cur_addr_d = in_addr;
        rem_d      = in_size;
        id_d       = in_id;
        first_d    = 1'b1;
        bypass_d   = ~split_en;
      end else if (!out_hs) begin
        // A zero-size request taken alongside a last chunk shares the single done
        // slot; the completing parent keeps it.
        done_d    = 1'b1;
        done_id_d = in_id;
      end
    end
  end

  always_comb begin
    out_valid   = (state_q == ISSUE);
    out_addr    = cur_addr_q;
    out_size    = chunk;
    out_id      = id_q;
    out_first   = out_valid & first_q;
    out_last    = out_valid & (chunk == rem_q);
    busy        = out_valid;
    req_done    = done_q;
    req_done_id = done_id_q;
    in_ready    = ~out_valid | (out_ready & out_last);
  end

endmodule

// File: tb/tb_mem_burst_splitter.sv
// Bench for mem_burst_splitter: directed scenarios plus random traffic, checked
// against a queue of expected sub-requests computed arithmetically per request.
module tb_mem_burst_splitter;

  localparam int AW = 64;
  localparam int SW = 16;
  localparam int BL = 12;
  localparam int ML = 8;
  localparam int IW = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [SW-1:0] size;
    logic [IW-1:0] id;
    logic          first;
    logic          last;
  } chunk_t;
  localparam int CHUNK_W = $bits(chunk_t);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          split_en = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] in_addr = '0;
  logic [SW-1:0] in_size = '0;
  logic [IW-1:0] in_id = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [AW-1:0] out_addr;
  logic [SW-1:0] out_size;
  logic [IW-1:0] out_id;
  logic          out_first;
  logic          out_last;
  logic          busy;
  logic          req_done;
  logic [IW-1:0] req_done_id;

  mem_burst_splitter #(
    .ADDR_WIDTH(AW), .REQ_SIZE_WIDTH(SW), .BOUNDARY_LOG2(BL),
    .MAX_BURST_LOG2(ML), .ID_WIDTH(IW)
  ) dut (
    .clk(clk), .reset(reset), .split_en(split_en),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_size(in_size), .in_id(in_id),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_size(out_size), .out_id(out_id),
    .out_first(out_first), .out_last(out_last),
    .busy(busy), .req_done(req_done), .req_done_id(req_done_id)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int vectors = 0;
  int miscompares = 0;
  logic [CHUNK_W-1:0] exp_q[$];
  logic          exp_done_v = 1'b0;
  logic [IW-1:0] exp_done_id = '0;
  logic          acc_flag = 1'b0;
  int            rdy_mode = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: split a request with plain arithmetic into its expected chunk list.
  task automatic model_request(input logic [AW-1:0] addr, input logic [SW-1:0] size,
                               input logic [IW-1:0] id, input logic bypass);
    logic [AW-1:0] a;
    int unsigned   rem, bnd, c;
    logic          first;
    chunk_t        ch;
    a     = addr;
    rem   = 32'(size);
    first = 1'b1;
    while (rem != 0) begin
      c = rem;
      if (!bypass) begin
        bnd = (32'd1 << BL) - 32'(a[BL-1:0]);
        if (bnd < c) c = bnd;
        if ((32'd1 << ML) < c) c = 32'd1 << ML;
      end
      ch.addr  = a;
      ch.size  = SW'(c);
      ch.id    = id;
      ch.first = first;
      ch.last  = (c == rem);
      exp_q.push_back(ch);
      a     = a + 64'(c);
      rem   = rem - c;
      first = 1'b0;
    end
  endtask

  chunk_t mon_head;
  logic   mon_rdy;

  always @(negedge clk) begin
    if (reset) begin
      check("req_done", 64'(req_done), 64'(exp_done_v));
      if (exp_done_v) check("req_done_id", 64'(req_done_id), 64'(exp_done_id));
      check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      mon_rdy = 1'b1;
      if (exp_q.size() != 0) begin
        mon_head = chunk_t'(exp_q[0]);
        check("out_addr", out_addr, mon_head.addr);
        check("out_size", 64'(out_size), 64'(mon_head.size));
        check("out_id", 64'(out_id), 64'(mon_head.id));
        check("out_first", 64'(out_first), 64'(mon_head.first));
        check("out_last", 64'(out_last), 64'(mon_head.last));
        check("busy", 64'(busy), 64'd1);
        mon_rdy = out_ready && mon_head.last;
      end else begin
        check("busy", 64'(busy), 64'd0);
      end
      check("in_ready", 64'(in_ready), 64'(mon_rdy));
      exp_done_v = 1'b0;
      if (exp_q.size() != 0 && out_ready) begin
        void'(exp_q.pop_front());
        if (mon_head.last) begin
          exp_done_v  = 1'b1;
          exp_done_id = mon_head.id;
        end
      end
      acc_flag = in_valid && mon_rdy;
      if (acc_flag) begin
        if (in_size == '0) begin
          if (!exp_done_v) begin
            exp_done_v  = 1'b1;
            exp_done_id = in_id;
          end
        end else begin
          model_request(in_addr, in_size, in_id, !split_en);
        end
      end
    end else begin
      acc_flag = 1'b0;
    end
  end

  // out_ready driver: 0 = always ready, 1 = random, 2 = stalled
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [AW-1:0] addr, input logic [SW-1:0] size,
                      input logic [IW-1:0] id, input logic split);
    int n;
    in_addr  = addr;
    in_size  = size;
    in_id    = id;
    split_en = split;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!acc_flag && n < 400);
    check("accepted", 64'(acc_flag), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    idle(2);
  endtask

  initial begin
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_first", 64'(out_first), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_out_size", 64'(out_size), 64'd0);
    check("rst_out_addr", out_addr, 64'd0);
    check("rst_out_id", 64'(out_id), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_req_done", 64'(req_done), 64'd0);
    check("rst_req_done_id", 64'(req_done_id), 64'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1 check("rst_in_ready", 64'(in_ready), 64'd1);
    idle(1);

    // boundary cross, burst cap, bypass, address wrap
    send(64'h0FF0, 16'h0040, 4'h1, 1'b1);
    drain();
    send(64'h2000, 16'h0300, 4'h2, 1'b1);
    drain();
    send(64'h0FF0, 16'h0040, 4'h3, 1'b0);
    drain();
    send(64'hFFFF_FFFF_FFFF_FFF0, 16'h0040, 4'h4, 1'b1);
    drain();

    // backpressure with the next request waiting
    send(64'h3F80, 16'h0300, 4'h6, 1'b1);
    fork
      send(64'h5000, 16'h0020, 4'h7, 1'b1);
      begin
        @(posedge clk);
        rdy_mode = 2;
        repeat (5) @(posedge clk);
        rdy_mode = 0;
      end
    join
    drain();

    // zero size, then back-to-back single-chunk requests
    send(64'h0100, 16'h0000, 4'h5, 1'b1);
    idle(2);
    send(64'h0010, 16'h0010, 4'h1, 1'b1);
    send(64'h0020, 16'h0010, 4'h2, 1'b1);
    send(64'h0030, 16'h0010, 4'h3, 1'b1);
    drain();

    // reset during the second of three chunks
    send(64'h2000, 16'h0300, 4'h8, 1'b1);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_req_done", 64'(req_done), 64'd0);
    check("midrst_out_size", 64'(out_size), 64'd0);
    exp_q.delete();
    exp_done_v = 1'b0;
    acc_flag   = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1 check("midrst_in_ready", 64'(in_ready), 64'd1);
    idle(2);
    send(64'h0FF0, 16'h0040, 4'h9, 1'b1);
    drain();

    // random traffic
    rdy_mode = 1;
    for (int i = 0; i < 250; i++) begin
      logic [AW-1:0] a;
      logic [SW-1:0] s;
      if ($urandom_range(0, 1) == 1)
        a = {$urandom, $urandom};
      else
        a = 64'(($urandom_range(0, 15) << BL) + $urandom_range(0, 4095) - 32'($urandom_range(0, 1) * 0));
      s = ($urandom_range(0, 3) == 0) ? SW'($urandom_range(1, 16)) : SW'($urandom_range(1, 16'h0900));
      send(a, s, IW'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 2) == 0) begin
        split_en = $urandom_range(0, 1) == 1;
        idle($urandom_range(1, 3));
      end
    end
    rdy_mode = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
